// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit CPU: sequencer state codes, opcodes and instruction fields.
// The control LUT imports the same package, so both sides agree on the encodings.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'b000,
        DECODE    = 3'b001,
        EXECUTE   = 3'b010,
        WRITEBACK = 3'b011,
        OUTPUT    = 3'b100
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'hA;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 3;
    localparam int DEST_LSB   = 4;
    localparam int DEST_MSB   = 5;
    localparam int SRC2_LSB   = 6;
    localparam int SRC2_MSB   = 7;

    function automatic logic [3:0] opcode_of(input logic [7:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction handshake, LUT hookup and debug readout of the sequencer.
// The master side feeds instructions and the LUT decode result; the slave is the sequencer.
interface cpu_sequencer_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       instr_in;
    logic             instr_valid;
    logic             instr_ready;
    logic             decode_zero;
    logic [7:0]       ir;
    logic [2:0]       state;
    logic             out_valid;
    logic             illegal;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output instr_in, instr_valid, decode_zero,
        input  instr_ready, ir, state, out_valid, illegal, retired_cnt, illegal_cnt
    );

    modport slave (
        input  instr_in, instr_valid, decode_zero,
        output instr_ready, ir, state, out_valid, illegal, retired_cnt, illegal_cnt
    );

endinterface

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: latches an instruction byte and steps FETCH/DECODE/EXECUTE/WRITEBACK/OUTPUT,
// aborting instructions whose LUT control word is zero and counting retired/illegal instructions.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    cpu_sequencer_if.slave  bus
);

    state_t           state_q,       state_d;
    logic [7:0]       ir_q,          ir_d;
    logic             illegal_q,     illegal_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic             run_q,         run_d;
    logic             instr_ready;

    // run_q keeps instr_ready low until the first enabled edge after reset releases
    assign instr_ready = ena && run_q && (state_q == FETCH);

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        illegal_d     = illegal_q;
        retired_cnt_d = retired_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        run_d         = run_q;
        if (ena) begin
            run_d     = 1'b1;
            illegal_d = 1'b0;
            case (state_q)
                FETCH: begin
                    if (bus.instr_valid && instr_ready) begin
                        ir_d    = bus.instr_in;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    if (bus.decode_zero) begin
                        illegal_d = 1'b1;
                        if (illegal_cnt_q != {CNT_W{1'b1}}) begin
                            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
                        end
                        state_d = FETCH;
                    end else begin
                        state_d = EXECUTE;
                    end
                end
                EXECUTE: begin
                    // NOP has nothing to write back, so it retires here
                    if (opcode_of(ir_q) == OP_NOP) begin
                        retired_cnt_d = retired_cnt_q + CNT_W'(1);
                        state_d       = FETCH;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end
                WRITEBACK: state_d = OUTPUT;
                OUTPUT: begin
                    retired_cnt_d = retired_cnt_q + CNT_W'(1);
                    state_d       = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            ir_q          <= 8'h00;
            illegal_q     <= 1'b0;
            retired_cnt_q <= '0;
            illegal_cnt_q <= '0;
            run_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            illegal_q     <= illegal_d;
            retired_cnt_q <= retired_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
            run_q         <= run_d;
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.ir          = ir_q;
    assign bus.state       = state_q;
    assign bus.out_valid   = (state_q == OUTPUT);
    assign bus.illegal     = illegal_q;
    assign bus.retired_cnt = retired_cnt_q;
    assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: inputs change and outputs are checked on the falling clock edge.
// Expected values are hand-computed from the state sequence of each instruction class.
module tb_cpu_sequencer;

    logic clk;
    logic rst_n;
    logic ena;
    int   checks_total;
    int   checks_passed;

    cpu_sequencer_if #(.CNT_W(8)) bus ();

    cpu_sequencer #(.CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic en, input logic valid,
                                 input logic [7:0] instr, input logic dz);
        ena             = en;
        bus.instr_valid = valid;
        bus.instr_in    = instr;
        bus.decode_zero = dz;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic checkState(input string tag, input logic [2:0] expected);
        checkOutput(tag, 32'(bus.state), 32'(expected));
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        #1 rst_n = 1'b0;

        // reset values
        @(negedge clk);
        checkState("rst_state", 3'd0);
        checkOutput("rst_ir", 32'(bus.ir), 32'h00);
        checkOutput("rst_ready", 32'(bus.instr_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_illegal", 32'(bus.illegal), 32'd0);
        checkOutput("rst_retired", 32'(bus.retired_cnt), 32'd0);
        checkOutput("rst_illcnt", 32'(bus.illegal_cnt), 32'd0);

        // normal instruction 8'h1B
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'h1B, 1'b0);
        @(negedge clk);
        checkOutput("ready_after_rst", 32'(bus.instr_ready), 32'd1);
        checkState("n_fetch", 3'd0);
        @(negedge clk);
        checkState("n_decode", 3'd1);
        checkOutput("n_ir", 32'(bus.ir), 32'h1B);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkState("n_execute", 3'd2);
        checkOutput("n_ov_exec", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        checkState("n_writeback", 3'd3);
        checkOutput("n_ov_wb", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        checkState("n_output", 3'd4);
        checkOutput("n_ov_out", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        checkState("n_back_fetch", 3'd0);
        checkOutput("n_ov_after", 32'(bus.out_valid), 32'd0);
        checkOutput("n_retired", 32'(bus.retired_cnt), 32'd1);

        // NOP 8'h00
        applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        checkState("nop_decode", 3'd1);
        applyStimulus(1'b1, 1'b0, 8'h55, 1'b0);
        @(negedge clk);
        checkState("nop_execute", 3'd2);
        checkOutput("nop_ov", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        checkState("nop_fetch", 3'd0);
        checkOutput("nop_ov_end", 32'(bus.out_valid), 32'd0);
        checkOutput("nop_retired", 32'(bus.retired_cnt), 32'd2);
        checkOutput("nop_ir", 32'(bus.ir), 32'h00);

        // illegal 8'hFF
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
        @(negedge clk);
        checkState("ill_decode", 3'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checkState("ill_fetch", 3'd0);
        checkOutput("ill_pulse", 32'(bus.illegal), 32'd1);
        checkOutput("ill_cnt1", 32'(bus.illegal_cnt), 32'd1);
        checkOutput("ill_retired", 32'(bus.retired_cnt), 32'd2);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("ill_pulse_end", 32'(bus.illegal), 32'd0);

        // 299 more illegals: check just below and at saturation
        for (int i = 0; i < 299; i++) begin
            applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
            if (i == 252) checkOutput("ill_cnt_fe", 32'(bus.illegal_cnt), 32'hFE);
        end
        checkOutput("ill_cnt_sat", 32'(bus.illegal_cnt), 32'hFF);
        checkState("ill_loop_fetch", 3'd0);

        // ena low in FETCH blocks the handshake
        applyStimulus(1'b0, 1'b1, 8'h37, 1'b0);
        @(negedge clk);
        checkOutput("frz_ready", 32'(bus.instr_ready), 32'd0);
        checkState("frz_fetch", 3'd0);
        checkOutput("frz_ir", 32'(bus.ir), 32'hFF);
        applyStimulus(1'b1, 1'b1, 8'h37, 1'b0);
        @(negedge clk);
        checkState("frz_decode", 3'd1);
        checkOutput("frz_ir_new", 32'(bus.ir), 32'h37);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkState("frz_execute", 3'd2);
        // ena low for 3 cycles in EXECUTE
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkState("frz_hold", 3'd2);
            checkOutput("frz_retired", 32'(bus.retired_cnt), 32'd2);
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkState("frz_writeback", 3'd3);
        @(negedge clk);
        checkState("frz_output", 3'd4);
        checkOutput("frz_ov", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        checkState("frz_done", 3'd0);
        checkOutput("frz_retired_end", 32'(bus.retired_cnt), 32'd3);
        checkOutput("frz_illcnt", 32'(bus.illegal_cnt), 32'hFF);

        // asynchronous reset during WRITEBACK
        applyStimulus(1'b1, 1'b1, 8'h1B, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkState("ar_writeback", 3'd3);
        #2 rst_n = 1'b0;
        #1;
        checkState("ar_state", 3'd0);
        checkOutput("ar_ir", 32'(bus.ir), 32'h00);
        checkOutput("ar_retired", 32'(bus.retired_cnt), 32'd0);
        checkOutput("ar_illcnt", 32'(bus.illegal_cnt), 32'd0);
        checkOutput("ar_ov", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("ar_ready_low", 32'(bus.instr_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h1B, 1'b0);
        @(negedge clk);
        checkOutput("ar_ready_high", 32'(bus.instr_ready), 32'd1);
        checkState("ar_fetch", 3'd0);
        @(negedge clk);
        checkState("ar_decode", 3'd1);
        checkOutput("ar_ir_new", 32'(bus.ir), 32'h1B);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("ar_ov_out", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        checkState("ar_done", 3'd0);
        checkOutput("ar_retired_end", 32'(bus.retired_cnt), 32'd1);

        // 256 back-to-back normal instructions, valid held high
        applyStimulus(1'b1, 1'b1, 8'h1B, 1'b0);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            checkState("b2b_decode", 3'd1);
            repeat (3) @(negedge clk);
            checkState("b2b_output", 3'd4);
            @(negedge clk);
            checkState("b2b_fetch", 3'd0);
            checkOutput("b2b_retired", 32'(bus.retired_cnt), 32'((2 + i) % 256));
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("b2b_final", 32'(bus.retired_cnt), 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
